// File: rtl/cpu_ext_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ext_loader_pkg
//  Description : Shared constants and phase-sequencing helper for the
//                external CPU memory loader (state encoding, byte strides).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ext_loader_pkg;

    // Session phases. Encoding order matches the session order, so
    // "later phase" can be tested with a plain magnitude compare.
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LD_I    = 3'd1;
    localparam logic [2:0] c_ST_LD_D    = 3'd2;
    localparam logic [2:0] c_ST_RUN     = 3'd3;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd4;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd5;
    localparam logic [2:0] c_ST_RD_OUT  = 3'd6;
    localparam logic [2:0] c_ST_DONE    = 3'd7;

    // Byte distance between consecutive words of each memory.
    localparam logic [63:0] c_IMEM_STRIDE = 64'd4;
    localparam logic [63:0] c_DMEM_STRIDE = 64'd8;

    // First phase strictly after 'after' whose length is non-zero; phases
    // with zero length are skipped so the whole hop happens in one cycle.
    // Later assignments override earlier ones, so the earliest phase wins.
    function automatic logic [2:0] next_phase(
        input logic [2:0] after,
        input logic       imem_nz,
        input logic       dmem_nz,
        input logic       run_nz,
        input logic       dump_nz
    );
        logic [2:0] nxt;
        nxt = c_ST_DONE;
        if (dump_nz && (after < c_ST_RD_REQ)) nxt = c_ST_RD_REQ;
        if (run_nz  && (after < c_ST_RUN))    nxt = c_ST_RUN;
        if (dmem_nz && (after < c_ST_LD_D))   nxt = c_ST_LD_D;
        if (imem_nz && (after < c_ST_LD_I))   nxt = c_ST_LD_I;
        return nxt;
    endfunction

endpackage : cpu_ext_loader_pkg
`default_nettype wire

// File: rtl/cpu_ext_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ext_loader
//  Description : Host-side initiator for the CPU external memory ports.
//                Streams a program into imem and an image into dmem, holds
//                cpu_enable for a programmed number of cycles, then reads a
//                region of dmem back out on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_ext_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [9:0]       imem_len,
    input  logic [10:0]      dmem_len,
    input  logic [CNT_W-1:0] run_len,
    input  logic [10:0]      dump_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
);
    import cpu_ext_loader_pkg::*;

    localparam logic [9:0]       c_IMEM_MAX = 10'(IMEM_DEPTH);
    localparam logic [10:0]      c_DMEM_MAX = 11'(DMEM_DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;

    // Session lengths, latched (and clamped) when a session starts.
    logic [9:0]       r_imem_len;
    logic [10:0]      r_dmem_len;
    logic [CNT_W-1:0] r_run_len;
    logic [10:0]      r_dump_len;

    // Word index shared by every phase; it is zero on entry to each phase.
    logic [10:0]      r_idx;
    logic [CNT_W-1:0] r_run_cnt;
    logic [63:0]      r_rd_data;

    logic [9:0]       w_imem_len_clamp;
    logic [10:0]      w_dmem_len_clamp;
    logic [10:0]      w_dump_len_clamp;
    logic [10:0]      w_idx_inc;
    logic             w_beat;
    logic             w_last_i;
    logic             w_last_d;
    logic             w_last_rd;
    logic             w_run_last;
    logic             w_imem_nz;
    logic             w_dmem_nz;
    logic             w_run_nz;
    logic             w_dump_nz;

    // Request lengths beyond the memory depth are trimmed to the depth.
    assign w_imem_len_clamp = (imem_len > c_IMEM_MAX) ? c_IMEM_MAX : imem_len;
    assign w_dmem_len_clamp = (dmem_len > c_DMEM_MAX) ? c_DMEM_MAX : dmem_len;
    assign w_dump_len_clamp = (dump_len > c_DMEM_MAX) ? c_DMEM_MAX : dump_len;

    // s_ready is only high in the load phases, so a beat implies LD_I/LD_D.
    assign w_beat     = s_valid && s_ready;
    assign w_idx_inc  = r_idx + 11'd1;
    assign w_last_i   = (w_idx_inc == {1'b0, r_imem_len});
    assign w_last_d   = (w_idx_inc == r_dmem_len);
    assign w_last_rd  = (w_idx_inc == r_dump_len);
    assign w_run_last = ((r_run_cnt + c_CNT_ONE) == r_run_len);

    assign w_imem_nz  = (r_imem_len != 10'd0);
    assign w_dmem_nz  = (r_dmem_len != 11'd0);
    assign w_run_nz   = (r_run_len  != '0);
    assign w_dump_nz  = (r_dump_len != 11'd0);

    // Phase sequencing; empty phases are hopped over in the same transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = next_phase(c_ST_IDLE,
                                              w_imem_len_clamp != 10'd0,
                                              w_dmem_len_clamp != 11'd0,
                                              run_len != '0,
                                              w_dump_len_clamp != 11'd0);
                end
            end
            c_ST_LD_I: begin
                if (w_beat && w_last_i) begin
                    w_state_next = next_phase(c_ST_LD_I, w_imem_nz, w_dmem_nz,
                                              w_run_nz, w_dump_nz);
                end
            end
            c_ST_LD_D: begin
                if (w_beat && w_last_d) begin
                    w_state_next = next_phase(c_ST_LD_D, w_imem_nz, w_dmem_nz,
                                              w_run_nz, w_dump_nz);
                end
            end
            c_ST_RUN: begin
                if (w_run_last) begin
                    w_state_next = next_phase(c_ST_RUN, w_imem_nz, w_dmem_nz,
                                              w_run_nz, w_dump_nz);
                end
            end
            c_ST_RD_REQ:  w_state_next = c_ST_RD_WAIT;
            c_ST_RD_WAIT: w_state_next = c_ST_RD_OUT;
            c_ST_RD_OUT: begin
                if (m_ready) begin
                    w_state_next = w_last_rd ? c_ST_DONE : c_ST_RD_REQ;
                end
            end
            c_ST_DONE:    w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    // State register; reset drops every phase output at once.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the session lengths on an accepted start only.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_imem_len <= 10'd0;
            r_dmem_len <= 11'd0;
            r_run_len  <= '0;
            r_dump_len <= 11'd0;
        end else if ((r_state == c_ST_IDLE) && start) begin
            r_imem_len <= w_imem_len_clamp;
            r_dmem_len <= w_dmem_len_clamp;
            r_run_len  <= run_len;
            r_dump_len <= w_dump_len_clamp;
        end
    end

    // Word index: advances per beat/readback, clears at the end of each load.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_idx <= 11'd0;
        end else if ((r_state == c_ST_LD_I) && w_beat) begin
            r_idx <= w_last_i ? 11'd0 : w_idx_inc;
        end else if ((r_state == c_ST_LD_D) && w_beat) begin
            r_idx <= w_last_d ? 11'd0 : w_idx_inc;
        end else if ((r_state == c_ST_RD_OUT) && m_ready) begin
            r_idx <= w_idx_inc;
        end else if ((r_state == c_ST_DONE) || (r_state == c_ST_IDLE)) begin
            r_idx <= 11'd0;
        end
    end

    // Run-cycle counter; only counts while the CPU is enabled.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_run_cnt <= '0;
        end else if ((r_state == c_ST_RUN) && !w_run_last) begin
            r_run_cnt <= r_run_cnt + c_CNT_ONE;
        end else begin
            r_run_cnt <= '0;
        end
    end

    // Readback holding register: dmem data lands one cycle after the read
    // strobe and stays put for the whole RD_OUT handshake.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rd_data <= 64'd0;
        end else if (r_state == c_ST_RD_WAIT) begin
            r_rd_data <= rdata_ext_2;
        end
    end

    // Port drive: everything is decoded from the state so that reset and
    // idle phases present all-zero outputs.
    always_comb begin
        s_ready     = 1'b0;
        wen_ext     = 1'b0;
        ren_ext     = 1'b0;
        addr_ext    = 64'd0;
        wdata_ext   = 32'd0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        addr_ext_2  = 64'd0;
        wdata_ext_2 = 64'd0;
        m_valid     = 1'b0;
        m_data      = 64'd0;
        cpu_enable  = 1'b0;
        busy        = (r_state != c_ST_IDLE);
        done        = (r_state == c_ST_DONE);
        case (r_state)
            c_ST_LD_I: begin
                s_ready   = 1'b1;
                wen_ext   = s_valid;
                addr_ext  = 64'(r_idx) * c_IMEM_STRIDE;
                wdata_ext = s_valid ? s_data[31:0] : 32'd0;
            end
            c_ST_LD_D: begin
                s_ready     = 1'b1;
                wen_ext_2   = s_valid;
                addr_ext_2  = 64'(r_idx) * c_DMEM_STRIDE;
                wdata_ext_2 = s_valid ? s_data : 64'd0;
            end
            c_ST_RUN: begin
                cpu_enable = 1'b1;
            end
            c_ST_RD_REQ: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = 64'(r_idx) * c_DMEM_STRIDE;
            end
            c_ST_RD_OUT: begin
                m_valid = 1'b1;
                m_data  = r_rd_data;
            end
            default: begin
            end
        endcase
    end

endmodule : cpu_ext_loader
`default_nettype wire

// File: tb/tb_cpu_ext_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ext_loader
//  Description : Self-checking bench for cpu_ext_loader with imem/dmem
//                models and queue-based scoreboards for writes and readback.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ext_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  imem_len = '0;
    logic [10:0] dmem_len = '0;
    logic [31:0] run_len = '0;
    logic [10:0] dump_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = '0;
    logic        cpu_enable;
    logic        busy;
    logic        done;

    cpu_ext_loader #(
        .IMEM_DEPTH(512),
        .DMEM_DEPTH(1024),
        .CNT_W(32)
    ) dut (
        .clk(clk), .arst(arst), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .run_len(run_len), .dump_len(dump_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboards: {addr, data} expected per write, expected readback words.
    logic [95:0]  iq[$];
    logic [127:0] dq[$];
    logic [63:0]  mq[$];
    logic [95:0]  e_i;
    logic [127:0] e_d;
    logic [63:0]  e_m;

    int imem_wr = 0, dmem_wr = 0, run_cyc = 0, cur_streak = 0, last_streak = 0;

    logic [63:0] dmem [0:1023];

    // dmem model: write on strobe, read data valid one cycle after ren.
    always @(posedge clk) begin
        if (!arst && wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (!arst && ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    // Output monitor: pops the scoreboards whenever the DUT produces something.
    always @(negedge clk) begin
        if (!arst) begin
            if (wen_ext) begin
                imem_wr++;
                n_vec++;
                if (iq.size() == 0) begin
                    n_err++;
                    $display("FAIL imem_write: got unexpected addr=%h data=%h, wanted no write", addr_ext, wdata_ext);
                end else begin
                    e_i = iq.pop_front();
                    if ({addr_ext, wdata_ext} !== e_i) begin
                        n_err++;
                        $display("FAIL imem_write: got addr=%h data=%h, wanted addr=%h data=%h",
                                 addr_ext, wdata_ext, e_i[95:32], e_i[31:0]);
                    end
                end
            end
            if (wen_ext_2) begin
                dmem_wr++;
                n_vec++;
                if (dq.size() == 0) begin
                    n_err++;
                    $display("FAIL dmem_write: got unexpected addr=%h data=%h, wanted no write", addr_ext_2, wdata_ext_2);
                end else begin
                    e_d = dq.pop_front();
                    if ({addr_ext_2, wdata_ext_2} !== e_d) begin
                        n_err++;
                        $display("FAIL dmem_write: got addr=%h data=%h, wanted addr=%h data=%h",
                                 addr_ext_2, wdata_ext_2, e_d[127:64], e_d[63:0]);
                    end
                end
            end
            if (m_valid && m_ready) begin
                n_vec++;
                if (mq.size() == 0) begin
                    n_err++;
                    $display("FAIL readback: got unexpected word %h, wanted none", m_data);
                end else begin
                    e_m = mq.pop_front();
                    if (m_data !== e_m) begin
                        n_err++;
                        $display("FAIL readback: got %h, wanted %h", m_data, e_m);
                    end
                end
            end
            if (cpu_enable) begin
                run_cyc++;
                cur_streak++;
                if (wen_ext || ren_ext || wen_ext_2 || ren_ext_2) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ext_during_run: got strobes %b%b%b%b, wanted 0000",
                             wen_ext, ren_ext, wen_ext_2, ren_ext_2);
                end
            end else if (cur_streak != 0) begin
                last_streak = cur_streak;
                cur_streak  = 0;
            end
        end
    end

    function automatic logic any_out();
        return |{s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, m_valid, cpu_enable,
                 busy, done, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, m_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [9:0] il, input logic [10:0] dl,
                                 input logic [31:0] rl, input logic [10:0] ul);
        imem_len = il; dmem_len = dl; run_len = rl; dump_len = ul;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] w, input bit gap);
        int t;
        if (gap) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_beat: s_ready stayed 0 for %0d cycles, wanted 1", t);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < limit);
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL done_timeout: done=0 after %0d cycles, wanted pulse", cyc);
        end
        tick();
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (any_out() !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero outputs, wanted all 0");
        end
        arst = 1'b0;
        tick();
        // Abort a dmem load while a write strobe is live.
        start_session(10'd0, 11'd4, 32'd0, 11'd0);
        dq.push_back({64'd0, 64'h0000_0000_DEAD_0001});
        dq.push_back({64'd8, 64'h0000_0000_DEAD_0002});
        send(64'h0000_0000_DEAD_0001, 1'b0);
        s_valid = 1'b1;
        s_data  = 64'h0000_0000_DEAD_0002;
        @(negedge clk);
        n_vec++;
        if (wen_ext_2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_precond: wen_ext_2=%b, wanted 1", wen_ext_2);
        end
        #2 arst = 1'b1;
        #1;
        n_vec++;
        if (any_out() !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got nonzero outputs, wanted all 0");
        end
        tick();
        n_vec++;
        if ({any_out(), busy, s_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_next_cycle: any=%b busy=%b s_ready=%b, wanted 000", any_out(), busy, s_ready);
        end
        s_valid = 1'b0;
        tick();
        arst = 1'b0;
        tick();
        n_vec++;
        if (dq.size() != 0) begin
            n_err++;
            $display("FAIL reset_writes: %0d expected dmem writes left, wanted 0", dq.size());
        end
        dq.delete();
    endtask

    task automatic test_load();
        int i0, d0, r0, cyc;
        logic [63:0] w [5];
        w = '{64'h1, 64'h2, 64'h3, 64'hA, 64'hB};
        i0 = imem_wr; d0 = dmem_wr; r0 = run_cyc;
        iq.push_back({64'd0, 32'h1});
        iq.push_back({64'd4, 32'h2});
        iq.push_back({64'd8, 32'h3});
        dq.push_back({64'd0, 64'hA});
        dq.push_back({64'd8, 64'hB});
        start_session(10'd3, 11'd2, 32'd0, 11'd0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_busy: busy=%b, wanted 1", busy);
        end
        for (int k = 0; k < 5; k++) send(w[k], 1'b0);
        wait_done(20, cyc);
        n_vec++;
        if ({imem_wr - i0, dmem_wr - d0} !== {32'd3, 32'd2}) begin
            n_err++;
            $display("FAIL load_counts: imem=%0d dmem=%0d, wanted 3 2", imem_wr - i0, dmem_wr - d0);
        end
        n_vec++;
        if (iq.size() + dq.size() != 0 || run_cyc != r0) begin
            n_err++;
            $display("FAIL load_tail: left=%0d run_cycles=%0d, wanted 0 0", iq.size() + dq.size(), run_cyc - r0);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_idle_busy: busy=%b, wanted 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int i0, d0, cyc;
        logic [63:0] w [7];
        i0 = imem_wr; d0 = dmem_wr;
        for (int k = 0; k < 7; k++) begin
            w[k] = {$urandom, $urandom};
            if (k < 4) iq.push_back({64'(k * 4), w[k][31:0]});
            else       dq.push_back({64'((k - 4) * 8), w[k]});
        end
        start_session(10'd4, 11'd3, 32'd0, 11'd0);
        for (int k = 0; k < 7; k++) begin
            send(w[k], 1'b1);
            if (k == 1) begin
                // A start in mid-session must not restart or re-latch.
                imem_len = 10'd1;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done(20, cyc);
        n_vec++;
        if ({imem_wr - i0, dmem_wr - d0} !== {32'd4, 32'd3}) begin
            n_err++;
            $display("FAIL backpressure_counts: imem=%0d dmem=%0d, wanted 4 3", imem_wr - i0, dmem_wr - d0);
        end
        n_vec++;
        if (iq.size() + dq.size() != 0) begin
            n_err++;
            $display("FAIL backpressure_left: %0d writes missing, wanted 0", iq.size() + dq.size());
        end
    endtask

    task automatic test_run();
        int r0, cyc;
        r0 = run_cyc;
        start_session(10'd0, 11'd0, 32'd5, 11'd0);
        wait_done(50, cyc);
        n_vec++;
        if (run_cyc - r0 != 5) begin
            n_err++;
            $display("FAIL run_cycles: got %0d, wanted 5", run_cyc - r0);
        end
        n_vec++;
        if (last_streak != 5) begin
            n_err++;
            $display("FAIL run_consecutive: longest window %0d, wanted 5", last_streak);
        end
    endtask

    task automatic test_dump();
        int t, cyc;
        dq.push_back({64'd0, 64'h11});
        dq.push_back({64'd8, 64'h22});
        mq.push_back(64'h11);
        mq.push_back(64'h22);
        start_session(10'd0, 11'd2, 32'd0, 11'd2);
        send(64'h11, 1'b0);
        send(64'h22, 1'b0);
        t = 0;
        @(negedge clk);
        while (!m_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({m_valid, m_data} !== {1'b1, 64'h11}) begin
                n_err++;
                $display("FAIL dump_hold[%0d]: m_valid=%b m_data=%h, wanted 1 %h", k, m_valid, m_data, 64'h11);
            end
            if (k < 3) @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done(50, cyc);
        m_ready = 1'b0;
        n_vec++;
        if (mq.size() != 0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dump_tail: %0d words missing, m_valid=%b, wanted 0 0", mq.size(), m_valid);
        end
    endtask

    task automatic test_zero_clamp();
        int i0, d0, cyc;
        i0 = imem_wr; d0 = dmem_wr;
        start_session(10'd0, 11'd0, 32'd0, 11'd0);
        wait_done(2, cyc);
        n_vec++;
        if (imem_wr != i0 || dmem_wr != d0) begin
            n_err++;
            $display("FAIL zero_writes: got %0d writes, wanted 0", imem_wr - i0 + dmem_wr - d0);
        end
        i0 = imem_wr;
        for (int k = 0; k < 512; k++) iq.push_back({64'(k * 4), 32'hA5A5_0000 ^ 32'(k)});
        start_session(10'd600, 11'd0, 32'd0, 11'd0);
        for (int k = 0; k < 512; k++) send({32'd0, 32'hA5A5_0000 ^ 32'(k)}, 1'b0);
        wait_done(10, cyc);
        s_valid = 1'b1;
        s_data  = 64'hFFFF;
        tick();
        tick();
        n_vec++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clamp_ready: s_ready=%b after session, wanted 0", s_ready);
        end
        s_valid = 1'b0;
        n_vec++;
        if (imem_wr - i0 != 512 || iq.size() != 0) begin
            n_err++;
            $display("FAIL clamp_count: got %0d imem writes, wanted 512", imem_wr - i0);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_backpressure();
        test_run();
        test_dump();
        test_zero_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at %0t, wanted finish", $time);
        $fatal(1);
    end

endmodule : tb_cpu_ext_loader
`default_nettype wire
